// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush/halt sequencer: FSM states and
// bit positions of the packed pipeline-register enable vector.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALTED   = 2'd2,
      RESUME   = 2'd3
   } state_e;

   localparam int EN_W      = 5;
   localparam int EN_PC     = 0;
   localparam int EN_IF_ID  = 1;
   localparam int EN_ID_EX  = 2;
   localparam int EN_EX_MEM = 3;
   localparam int EN_MEM_WB = 4;

   localparam logic [EN_W-1:0] EN_ALL  = 5'b11111;
   localparam logic [EN_W-1:0] EN_NONE = 5'b00000;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, pipeline-register enables/clears and statistics exchanged
// between the datapath (master) and the sequencer (slave).
interface pipeline_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             ex_memread;
   logic [4:0]       ex_wr;
   logic             br_taken;
   logic             mem_busy;
   logic             halt_wb;
   logic             go;
   logic             en_pc;
   logic             en_if_id;
   logic             en_id_ex;
   logic             en_ex_mem;
   logic             en_mem_wb;
   logic             clr_if_id;
   logic             clr_id_ex;
   logic             clr_mem_wb;
   logic             halted;
   logic             err;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_wr,
             br_taken, mem_busy, halt_wb, go,
      input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
             clr_if_id, clr_id_ex, clr_mem_wb, halted, err,
             cycle_cnt, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_wr,
             br_taken, mem_busy, halt_wb, go,
      output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
             clr_if_id, clr_id_ex, clr_mem_wb, halted, err,
             cycle_cnt, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the ID instruction reads a register that
// the load in EX has not yet produced. $zero never creates a dependency.
module load_use_detect (
   input  logic       ex_memread,
   input  logic [4:0] ex_wr,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   output logic       hazard
);

   // Match either live source operand against the pending load destination
   always_comb begin
      hazard = ex_memread & (ex_wr != 5'd0) &
               ((id_use_rs & (id_rs == ex_wr)) | (id_use_rt & (id_rt == ex_wr)));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/halt sequencer for the five-stage pipeline: decodes enables and
// bubble clears with zero latency and keeps cycle/stall/flush statistics.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   pipeline_ctrl_if.slave bus
);

   localparam int               BUSY_W    = $clog2(WAIT_MAX);
   localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(WAIT_MAX - 1);

   state_e            state_r, state_s;
   logic              go_q_r, go_rise_r;
   logic [BUSY_W-1:0] busy_run_r;
   logic              err_r;
   logic [CNT_W-1:0]  cycle_cnt_r, stall_cnt_r, flush_cnt_r;

   logic              load_use_s;
   logic [EN_W-1:0]   fr_en_s;
   logic              fr_clr_if_id_s, fr_clr_id_ex_s, fr_stall_s, fr_flush_s;
   logic [EN_W-1:0]   en_s;
   logic              clr_if_id_s, clr_id_ex_s, clr_mem_wb_s;
   logic              stall_inc_s, flush_inc_s, err_set_s;

   load_use_detect u_load_use (
      .ex_memread (bus.ex_memread),
      .ex_wr      (bus.ex_wr),
      .id_rs      (bus.id_rs),
      .id_rt      (bus.id_rt),
      .id_use_rs  (bus.id_use_rs),
      .id_use_rt  (bus.id_use_rt),
      .hazard     (load_use_s)
   );

   // Free-flowing decode; branch wins over load-use since the stalled op is flushed
   always_comb begin
      fr_en_s        = EN_ALL;
      fr_clr_if_id_s = 1'b0;
      fr_clr_id_ex_s = 1'b0;
      fr_stall_s     = 1'b0;
      fr_flush_s     = 1'b0;
      if (bus.br_taken) begin
         fr_clr_if_id_s = 1'b1;
         fr_clr_id_ex_s = 1'b1;
         fr_flush_s     = 1'b1;
      end else if (load_use_s) begin
         fr_en_s[EN_PC]    = 1'b0;
         fr_en_s[EN_IF_ID] = 1'b0;
         fr_clr_id_ex_s    = 1'b1;
         fr_stall_s        = 1'b1;
      end else begin
         fr_en_s = EN_ALL;
      end
   end

   // Next-state and enable/clear decode
   always_comb begin
      state_s      = state_r;
      en_s         = EN_NONE;
      clr_if_id_s  = 1'b0;
      clr_id_ex_s  = 1'b0;
      clr_mem_wb_s = 1'b0;
      stall_inc_s  = 1'b0;
      flush_inc_s  = 1'b0;
      err_set_s    = 1'b0;
      case (state_r)
         RUN, MEM_WAIT, RESUME: begin
            if (bus.halt_wb && (state_r != RESUME)) begin
               state_s = HALTED;
            end else if (bus.mem_busy) begin
               en_s[EN_MEM_WB] = 1'b1;
               clr_mem_wb_s    = 1'b1;
               stall_inc_s     = 1'b1;
               if (busy_run_r == BUSY_LAST) begin
                  err_set_s = 1'b1;
                  state_s   = HALTED;
               end else begin
                  state_s = MEM_WAIT;
               end
            end else begin
               en_s        = fr_en_s;
               clr_if_id_s = fr_clr_if_id_s;
               clr_id_ex_s = fr_clr_id_ex_s;
               stall_inc_s = fr_stall_s;
               flush_inc_s = fr_flush_s;
               state_s     = RUN;
            end
         end
         HALTED: begin
            if (go_rise_r && !err_r) begin
               state_s = RESUME;
            end else begin
               state_s = HALTED;
            end
         end
         default: state_s = RUN;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= RUN;
      end else begin
         state_r <= state_s;
      end
   end

   // GO edges are only kept when sampled in HALTED, so one arriving on entry is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         go_q_r    <= 1'b0;
         go_rise_r <= 1'b0;
      end else begin
         go_q_r    <= bus.go;
         go_rise_r <= (state_r == HALTED) & bus.go & ~go_q_r;
      end
   end

   // Consecutive MEM_BUSY run length, saturating at the timeout threshold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_run_r <= '0;
      end else if (!bus.mem_busy) begin
         busy_run_r <= '0;
      end else if (busy_run_r != BUSY_LAST) begin
         busy_run_r <= busy_run_r + BUSY_W'(1);
      end else begin
         busy_run_r <= busy_run_r;
      end
   end

   // Sticky timeout flag and wrapping statistics counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r       <= 1'b0;
         cycle_cnt_r <= '0;
         stall_cnt_r <= '0;
         flush_cnt_r <= '0;
      end else begin
         if (err_set_s) begin
            err_r <= 1'b1;
         end
         if (state_r != HALTED) begin
            cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
         end
         if (stall_inc_s) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end
         if (flush_inc_s) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1);
         end
      end
   end

   assign bus.en_pc      = rst_n & en_s[EN_PC];
   assign bus.en_if_id   = rst_n & en_s[EN_IF_ID];
   assign bus.en_id_ex   = rst_n & en_s[EN_ID_EX];
   assign bus.en_ex_mem  = rst_n & en_s[EN_EX_MEM];
   assign bus.en_mem_wb  = rst_n & en_s[EN_MEM_WB];
   assign bus.clr_if_id  = rst_n & clr_if_id_s;
   assign bus.clr_id_ex  = rst_n & clr_id_ex_s;
   assign bus.clr_mem_wb = rst_n & clr_mem_wb_s;
   assign bus.halted     = (state_r == HALTED);
   assign bus.err        = err_r;
   assign bus.cycle_cnt  = cycle_cnt_r;
   assign bus.stall_cnt  = stall_cnt_r;
   assign bus.flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with CNT_W=4, WAIT_MAX=4.
module tb_pipeline_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pipeline_ctrl_if #(.CNT_W(4)) bus();

   pipeline_ctrl #(.CNT_W(4), .WAIT_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string      tag;
      logic [4:0] en;
      logic [2:0] clr;
      logic       halted;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   checks     = 0;
   int   failures   = 0;
   int   exp_cycle  = 0;
   int   exp_stall  = 0;
   int   exp_flush  = 0;

   localparam logic [4:0] ALL  = 5'b11111;
   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] LU   = 5'b11100;
   localparam logic [4:0] MEMW = 5'b10000;

   function automatic logic [4:0] en_obs();
      return {bus.en_mem_wb, bus.en_ex_mem, bus.en_id_ex, bus.en_if_id, bus.en_pc};
   endfunction

   function automatic logic [2:0] clr_obs();
      return {bus.clr_mem_wb, bus.clr_id_ex, bus.clr_if_id};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_cycle"}, 32'(bus.cycle_cnt), 32'(exp_cycle % 16));
      chk({tag, "_stall"}, 32'(bus.stall_cnt), 32'(exp_stall % 16));
      chk({tag, "_flush"}, 32'(bus.flush_cnt), 32'(exp_flush % 16));
   endtask

   task automatic neutral();
      bus.id_rs      = 5'd0;
      bus.id_rt      = 5'd0;
      bus.id_use_rs  = 1'b0;
      bus.id_use_rt  = 1'b0;
      bus.ex_memread = 1'b0;
      bus.ex_wr      = 5'd0;
      bus.br_taken   = 1'b0;
      bus.mem_busy   = 1'b0;
      bus.halt_wb    = 1'b0;
      bus.go         = 1'b0;
   endtask

   // One pipeline cycle: push expectation, check mid-cycle, advance past the edge
   task automatic cyc(input string tag, input logic [4:0] en, input logic [2:0] clr,
                      input logic halted, input logic err);
      exp_t e;
      e.tag = tag; e.en = en; e.clr = clr; e.halted = halted; e.err = err;
      sb.push_back(e);
      #3;
      e = sb.pop_front();
      chk({e.tag, "_en"},     32'(en_obs()),   32'(e.en));
      chk({e.tag, "_clr"},    32'(clr_obs()),  32'(e.clr));
      chk({e.tag, "_halted"}, 32'(bus.halted), 32'(e.halted));
      chk({e.tag, "_err"},    32'(bus.err),    32'(e.err));
      @(posedge clk);
      #1;
      if (!e.halted) exp_cycle++;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      neutral();
      bus.br_taken = 1'b1;
      bus.mem_busy = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_en",     32'(en_obs()),   32'(NONE));
      chk("rst_clr",    32'(clr_obs()),  32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_err",    32'(bus.err),    32'd0);
      chk_cnt("rst");
      @(posedge clk);
      @(posedge clk);
      #1;
      neutral();
      rst_n = 1'b1;

      cyc("idle", ALL, 3'b000, 1'b0, 1'b0);

      bus.ex_memread = 1'b1; bus.ex_wr = 5'd5; bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
      cyc("lu_rs", LU, 3'b010, 1'b0, 1'b0);
      exp_stall++;
      chk_cnt("lu_rs");

      bus.ex_wr = 5'd0; bus.id_rs = 5'd0;
      cyc("lu_r0", ALL, 3'b000, 1'b0, 1'b0);

      bus.ex_wr = 5'd7; bus.id_rt = 5'd7; bus.id_use_rt = 1'b1; bus.id_rs = 5'd3;
      cyc("lu_rt", LU, 3'b010, 1'b0, 1'b0);
      exp_stall++;

      bus.id_use_rt = 1'b0;
      cyc("lu_nouse", ALL, 3'b000, 1'b0, 1'b0);

      bus.id_use_rt = 1'b1; bus.ex_memread = 1'b0;
      cyc("lu_noload", ALL, 3'b000, 1'b0, 1'b0);
      chk_cnt("lu_done");

      neutral();
      bus.ex_memread = 1'b1; bus.ex_wr = 5'd5; bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
      bus.br_taken = 1'b1;
      cyc("br_lu", ALL, 3'b011, 1'b0, 1'b0);
      exp_flush++;
      chk_cnt("br_lu");

      neutral();
      bus.mem_busy = 1'b1;
      repeat (3) cyc("mw", MEMW, 3'b100, 1'b0, 1'b0);
      exp_stall += 3;
      bus.mem_busy = 1'b0; bus.br_taken = 1'b1;
      cyc("mw_exit_br", ALL, 3'b011, 1'b0, 1'b0);
      exp_flush++;
      neutral();
      cyc("mw_run", ALL, 3'b000, 1'b0, 1'b0);
      chk_cnt("mw");

      // GO rising as HALTED is entered and then held high must not resume
      bus.halt_wb = 1'b1; bus.go = 1'b1;
      cyc("h_entry", NONE, 3'b000, 1'b0, 1'b0);
      cyc("h_held1", NONE, 3'b000, 1'b1, 1'b0);
      cyc("h_held2", NONE, 3'b000, 1'b1, 1'b0);
      bus.go = 1'b0;
      cyc("h_low", NONE, 3'b000, 1'b1, 1'b0);
      bus.go = 1'b1;
      cyc("h_go", NONE, 3'b000, 1'b1, 1'b0);
      bus.go = 1'b0;
      cyc("h_wait", NONE, 3'b000, 1'b1, 1'b0);
      cyc("h_resume", ALL, 3'b000, 1'b0, 1'b0);
      bus.halt_wb = 1'b0;
      cyc("h_run", ALL, 3'b000, 1'b0, 1'b0);
      chk_cnt("halt");

      neutral();
      bus.mem_busy = 1'b1;
      repeat (4) cyc("to_busy", MEMW, 3'b100, 1'b0, 1'b0);
      exp_stall += 4;
      cyc("to_halt", NONE, 3'b000, 1'b1, 1'b1);
      bus.mem_busy = 1'b0; bus.go = 1'b1;
      cyc("to_go", NONE, 3'b000, 1'b1, 1'b1);
      bus.go = 1'b0;
      cyc("to_ign1", NONE, 3'b000, 1'b1, 1'b1);
      cyc("to_ign2", NONE, 3'b000, 1'b1, 1'b1);
      chk_cnt("timeout");

      #2 rst_n = 1'b0;
      #1;
      chk("arst_err",    32'(bus.err),    32'd0);
      chk("arst_halted", 32'(bus.halted), 32'd0);
      exp_cycle = 0; exp_stall = 0; exp_flush = 0;
      chk_cnt("arst");
      @(posedge clk);
      #1 rst_n = 1'b1;

      repeat (17) cyc("wrap", ALL, 3'b000, 1'b0, 1'b0);
      chk("wrap_cycle", 32'(bus.cycle_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
